// File: rtl/imm_gen_stage.sv
// Registered immediate generator at the ID->EX boundary, with a 2-entry skid buffer
// (head + skid) so EX stalls and flushes never lose or duplicate instructions.
module imm_gen_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [2:0]       imm_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic [1:0]       occupancy
);

    logic [XLEN-1:0]  head_imm_q, head_imm_d, skid_imm_q, skid_imm_d;
    logic [TAG_W-1:0] head_tag_q, head_tag_d, skid_tag_q, skid_tag_d;
    logic             head_ill_q, head_ill_d, skid_ill_q, skid_ill_d;
    logic [1:0]       occ_q, occ_d;
    logic             in_ready_q, in_ready_d;

    logic signed [31:0] imm32;
    logic [XLEN-1:0]    new_imm;
    logic               new_ill;
    logic               accept, pop;

    // Opcode bits never contribute to any immediate format.
    logic unused_opcode;
    assign unused_opcode = ^inst[6:0];

    // Every signed format carries inst[31] into bit 31, so a single signed
    // widening from bit 31 covers both XLEN=32 and XLEN=64.
    always_comb begin
        imm32   = '0;
        new_ill = 1'b0;
        case (imm_sel)
            3'd0: imm32 = {{20{inst[31]}}, inst[31:20]};
            3'd1: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            3'd2: imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            3'd3: imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            3'd4,
            3'd5: imm32 = {inst[31:12], 12'h000};
            3'd6: imm32 = {27'd0, inst[19:15]};
            default: begin
                imm32   = '0;
                new_ill = 1'b1;
            end
        endcase
        new_imm = XLEN'(imm32);
    end

    always_comb begin
        head_imm_d = head_imm_q;
        head_tag_d = head_tag_q;
        head_ill_d = head_ill_q;
        skid_imm_d = skid_imm_q;
        skid_tag_d = skid_tag_q;
        skid_ill_d = skid_ill_q;
        occ_d      = occ_q;
        accept     = in_valid && in_ready_q && !flush;
        pop        = (occ_q != 2'd0) && out_ready && !flush;

        if (flush) begin
            occ_d = 2'd0;
        end else begin
            case (occ_q)
                2'd0: begin
                    if (accept) begin
                        head_imm_d = new_imm;
                        head_tag_d = in_tag;
                        head_ill_d = new_ill;
                        occ_d      = 2'd1;
                    end
                end
                2'd1: begin
                    if (accept && pop) begin
                        head_imm_d = new_imm;
                        head_tag_d = in_tag;
                        head_ill_d = new_ill;
                    end else if (accept) begin
                        skid_imm_d = new_imm;
                        skid_tag_d = in_tag;
                        skid_ill_d = new_ill;
                        occ_d      = 2'd2;
                    end else if (pop) begin
                        occ_d = 2'd0;
                    end
                end
                2'd2: begin
                    // Full: in_ready is low, so only a pop can happen here.
                    if (pop) begin
                        head_imm_d = skid_imm_q;
                        head_tag_d = skid_tag_q;
                        head_ill_d = skid_ill_q;
                        occ_d      = 2'd1;
                    end
                end
                default: occ_d = 2'd0;
            endcase
        end

        in_ready_d = (occ_d != 2'd2);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_imm_q <= '0;
            head_tag_q <= '0;
            head_ill_q <= 1'b0;
            skid_imm_q <= '0;
            skid_tag_q <= '0;
            skid_ill_q <= 1'b0;
            occ_q      <= 2'd0;
            in_ready_q <= 1'b0;
        end else begin
            head_imm_q <= head_imm_d;
            head_tag_q <= head_tag_d;
            head_ill_q <= head_ill_d;
            skid_imm_q <= skid_imm_d;
            skid_tag_q <= skid_tag_d;
            skid_ill_q <= skid_ill_d;
            occ_q      <= occ_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (occ_q != 2'd0);
    assign out_imm     = head_imm_q;
    assign out_tag     = head_tag_q;
    assign out_illegal = head_ill_q;
    assign occupancy   = occ_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: XLEN=32 and XLEN=64 instances share stimulus and are checked
// against a queue-based reference model, a vector table and hand-written corner sequences.
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] inst, in_tag;
    logic [2:0]  imm_sel;

    logic        in_ready32, out_valid32, out_ill32;
    logic [31:0] out_imm32, out_tag32;
    logic [1:0]  occ32;
    logic        in_ready64, out_valid64, out_ill64;
    logic [63:0] out_imm64;
    logic [31:0] out_tag64;
    logic [1:0]  occ64;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .inst(inst), .imm_sel(imm_sel), .in_tag(in_tag), .out_valid(out_valid32),
        .out_ready(out_ready), .out_imm(out_imm32), .out_tag(out_tag32),
        .out_illegal(out_ill32), .occupancy(occ32)
    );

    imm_gen_stage #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .inst(inst), .imm_sel(imm_sel), .in_tag(in_tag), .out_valid(out_valid64),
        .out_ready(out_ready), .out_imm(out_imm64), .out_tag(out_tag64),
        .out_illegal(out_ill64), .occupancy(occ64)
    );

    typedef struct {
        logic [63:0] imm;
        logic [31:0] tag;
        logic        ill;
    } ent_t;

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  sel;
        logic [31:0] exp32;
        logic [63:0] exp64;
        logic        ill;
    } vec_t;

    ent_t model_q[$];
    bit   rdy_ok   = 1'b0;
    bit   checking = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference immediate built from field weights with plain integer arithmetic.
    function automatic ent_t ref_entry(input logic [31:0] i, input logic [2:0] sel,
                                       input logic [31:0] tag);
        ent_t   e;
        longint v;
        v     = 0;
        e.tag = tag;
        e.ill = 1'b0;
        case (sel)
            3'd0: begin
                v = longint'(i[31:20]);
                if (i[31]) v = v - 4096;
            end
            3'd1: begin
                v = longint'(i[31:25]) * 32 + longint'(i[11:7]);
                if (i[31]) v = v - 4096;
            end
            3'd2: begin
                v = longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
                if (i[31]) v = v - 4096;
            end
            3'd3: begin
                v = longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
                if (i[31]) v = v - 1048576;
            end
            3'd4, 3'd5: begin
                v = longint'(i[30:12]) * 4096;
                if (i[31]) v = v - 64'sd2147483648;
            end
            3'd6: v = longint'(i[19:15]);
            default: begin
                v     = 0;
                e.ill = 1'b1;
            end
        endcase
        e.imm = v;
        return e;
    endfunction

    // One clock: compare both DUTs with the model, advance the model across the edge.
    task automatic step();
        int sz;
        bit acc, pop, exp_rdy;
        sz      = model_q.size();
        exp_rdy = rdy_ok && (sz < 2);
        if (checking) begin
            chk("in_ready32", in_ready32, exp_rdy);
            chk("in_ready64", in_ready64, exp_rdy);
            chk("occupancy32", occ32, sz);
            chk("occupancy64", occ64, sz);
            chk("out_valid32", out_valid32, sz > 0);
            chk("out_valid64", out_valid64, sz > 0);
            if (sz > 0) begin
                chk("out_imm32", out_imm32, model_q[0].imm[31:0]);
                chk("out_imm64", out_imm64, model_q[0].imm);
                chk("out_tag32", out_tag32, model_q[0].tag);
                chk("out_tag64", out_tag64, model_q[0].tag);
                chk("out_illegal32", out_ill32, model_q[0].ill);
                chk("out_illegal64", out_ill64, model_q[0].ill);
            end
        end
        acc = exp_rdy && in_valid && !flush;
        pop = (sz > 0) && out_ready && !flush;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_q.delete();
            rdy_ok = 1'b0;
        end else begin
            rdy_ok = 1'b1;
            if (flush) begin
                model_q.delete();
            end else begin
                if (pop) void'(model_q.pop_front());
                if (acc) model_q.push_back(ref_entry(inst, imm_sel, in_tag));
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_occupancy"}, occ32, 2'd0);
        chk({tag, "_out_valid"}, out_valid32, 1'b0);
        chk({tag, "_out_imm32"}, out_imm32, 32'd0);
        chk({tag, "_out_imm64"}, out_imm64, 64'd0);
        chk({tag, "_out_tag"}, out_tag32, 32'd0);
        chk({tag, "_out_illegal"}, out_ill32, 1'b0);
        chk({tag, "_in_ready"}, in_ready32, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        vecs[0] = '{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vecs[1] = '{32'h7FF00093, 3'd0, 32'h000007FF, 64'h00000000000007FF, 1'b0};
        vecs[2] = '{32'h02000223, 3'd1, 32'h00000024, 64'h0000000000000024, 1'b0};
        vecs[3] = '{32'hFE000FA3, 3'd1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vecs[4] = '{32'hFE000EE3, 3'd2, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        vecs[5] = '{32'h001000EF, 3'd3, 32'h00000800, 64'h0000000000000800, 1'b0};
        vecs[6] = '{32'h123450B7, 3'd4, 32'h12345000, 64'h0000000012345000, 1'b0};
        vecs[7] = '{32'h800000B7, 3'd5, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
        vecs[8] = '{32'h800F8073, 3'd6, 32'h0000001F, 64'h000000000000001F, 1'b0};
        vecs[9] = '{32'hFFFFFFFF, 3'd7, 32'h00000000, 64'h0000000000000000, 1'b1};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        inst = '0; imm_sel = '0; in_tag = '0;
        step();
        step();
        chk_reset_outputs("reset");

        rst_n    = 1'b1;
        checking = 1'b1;
        step();

        // Vector table: each entry must be at the head one cycle after acceptance.
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            inst     = vecs[k].inst;
            imm_sel  = vecs[k].sel;
            in_tag   = 32'h100 + k;
            step();
            chk($sformatf("vec%0d_valid", k), out_valid32, 1'b1);
            chk($sformatf("vec%0d_imm32", k), out_imm32, vecs[k].exp32);
            chk($sformatf("vec%0d_imm64", k), out_imm64, vecs[k].exp64);
            chk($sformatf("vec%0d_illegal", k), out_ill32, vecs[k].ill);
            chk($sformatf("vec%0d_tag", k), out_tag32, 32'h100 + k);
        end
        in_valid = 1'b0;
        step();

        // Backpressure: tags 1,2,3 offered with out_ready low.
        out_ready = 1'b0; in_valid = 1'b1; imm_sel = 3'd0; inst = 32'h00100093;
        in_tag = 32'd1; step();
        in_tag = 32'd2; step();
        in_tag = 32'd3;
        chk("bp_in_ready", in_ready32, 1'b0);
        chk("bp_occupancy", occ32, 2'd2);
        step();
        chk("bp_hold_tag", out_tag32, 32'd1);
        chk("bp_hold_occ", occ32, 2'd2);
        out_ready = 1'b1;
        step();
        chk("bp_tag2", out_tag32, 32'd2);
        chk("bp_recover_ready", in_ready32, 1'b1);
        step();
        in_valid = 1'b0;
        chk("bp_tag3", out_tag32, 32'd3);
        step();
        chk("bp_drained", out_valid32, 1'b0);

        // Flush with a full buffer and a same-cycle input.
        out_ready = 1'b0; in_valid = 1'b1;
        in_tag = 32'hA1; step();
        in_tag = 32'hA2; step();
        flush = 1'b1; in_tag = 32'h55;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_occupancy", occ32, 2'd0);
        chk("flush_out_valid", out_valid32, 1'b0);
        chk("flush_in_ready", in_ready32, 1'b1);
        step();
        chk("flush_input_dropped", out_valid32, 1'b0);

        // Reset while one entry is held.
        in_valid = 1'b1; in_tag = 32'hBEEF; imm_sel = 3'd4; inst = 32'hFFFFF0B7;
        step();
        in_valid = 1'b0;
        chk("rstmid_occ_before", occ32, 2'd1);
        rst_n = 1'b0;
        step();
        chk_reset_outputs("rstmid");
        rst_n = 1'b1;
        step();
        chk("rstmid_not_presented", out_valid32, 1'b0);
        chk("rstmid_ready_back", in_ready32, 1'b1);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            inst      = $urandom;
            imm_sel   = 3'($urandom_range(0, 7));
            in_tag    = $urandom;
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        step();
        chk("final_empty", occ32, 2'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
